// File: rtl/neureka_binconv_column_bitserial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neureka_binconv_column_bitserial: bit-serial binconv column, shift-add   |
// | over weight slices, signed/offset modes, valid/ready result. Rev 1.0     |
// +--------------------------------------------------------------------------+
module neureka_binconv_column_bitserial #(
  parameter int COLUMN_SIZE = 9,
  parameter int QA_IN       = 8,
  parameter int QW_MAX      = 8,
  parameter int SUM_W       = QA_IN + $clog2(COLUMN_SIZE) + 1,
  parameter int ACC_W       = SUM_W + QW_MAX + 1,
  localparam int QW_W       = $clog2(QW_MAX + 1),
  localparam int BC_W       = $clog2(QW_MAX)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [QW_W-1:0]              qw_i,
  input  logic                         signed_w_i,
  input  logic                         offset_mode_i,
  input  logic [3:0]                   offset_shift_i,
  input  logic [COLUMN_SIZE-1:0]       lane_en_i,
  input  logic                         act_valid_i,
  input  logic [COLUMN_SIZE*QA_IN-1:0] act_data_i,
  output logic                         act_ready_o,
  input  logic                         wt_valid_i,
  input  logic [COLUMN_SIZE-1:0]       wt_data_i,
  output logic                         wt_ready_o,
  output logic                         pres_valid_o,
  output logic [ACC_W-1:0]             pres_data_o,
  input  logic                         pres_ready_i,
  output logic                         busy_o,
  output logic [BC_W-1:0]              bit_cnt_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_OUT = 2'd2} state_t;

  state_t                 r_state;
  logic [ACC_W-1:0]       r_acc;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [BC_W-1:0]        r_qw_last;
  logic                   r_signed;
  logic                   r_offset;
  logic [3:0]             r_offset_shift;
  logic [COLUMN_SIZE-1:0] r_lane_en;

  logic [QW_W-1:0]        w_qw_eff;
  logic [BC_W-1:0]        w_qw_last;
  logic [COLUMN_SIZE-1:0] w_wbits;
  logic [SUM_W-1:0]       w_sum;
  logic [ACC_W-1:0]       w_term;
  logic [ACC_W-1:0]       w_acc_next;
  logic                   w_in_accum;
  logic                   w_is_msb;
  logic                   w_last;
  logic                   w_fire;

  // qw of 0 behaves as a single-bit job; oversize requests saturate at QW_MAX
  always_comb begin
    if (qw_i == '0)
      w_qw_eff = QW_W'(1);
    else if (qw_i > QW_W'(QW_MAX))
      w_qw_eff = QW_W'(QW_MAX);
    else
      w_qw_eff = qw_i;
    w_qw_last = BC_W'(w_qw_eff - QW_W'(1));
  end

  assign w_in_accum  = (r_state == S_ACCUM);
  assign w_is_msb    = (r_bit_cnt == r_qw_last);
  assign w_last      = r_offset | w_is_msb;
  assign act_ready_o = w_in_accum & (r_offset | wt_valid_i);
  assign wt_ready_o  = w_in_accum & ~r_offset & act_valid_i;
  assign w_fire      = w_in_accum & act_valid_i & (r_offset | wt_valid_i);

  always_comb begin
    w_wbits = r_offset ? {COLUMN_SIZE{1'b1}} : wt_data_i;
    w_sum   = '0;
    for (int i = 0; i < COLUMN_SIZE; i++) begin
      if (r_lane_en[i] & w_wbits[i])
        w_sum = w_sum + SUM_W'(act_data_i[i*QA_IN +: QA_IN]);
    end
    w_term = ACC_W'(w_sum) << r_bit_cnt;
    if (r_offset)
      w_acc_next = ACC_W'(w_sum) << r_offset_shift;
    else if (r_signed && w_is_msb)
      w_acc_next = r_acc - w_term;
    else
      w_acc_next = r_acc + w_term;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_bit_cnt      <= '0;
      r_qw_last      <= '0;
      r_signed       <= 1'b0;
      r_offset       <= 1'b0;
      r_offset_shift <= '0;
      r_lane_en      <= '0;
      pres_valid_o   <= 1'b0;
      pres_data_o    <= '0;
      busy_o         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_qw_last      <= w_qw_last;
            r_signed       <= signed_w_i;
            r_offset       <= offset_mode_i;
            r_offset_shift <= offset_shift_i;
            r_lane_en      <= lane_en_i;
            r_acc          <= '0;
            r_bit_cnt      <= '0;
            r_state        <= S_ACCUM;
            busy_o         <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_fire) begin
            r_acc     <= w_acc_next;
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
            if (w_last) begin
              r_state      <= S_OUT;
              pres_valid_o <= 1'b1;
              pres_data_o  <= w_acc_next;
            end
          end
        end
        S_OUT: begin
          if (pres_ready_i) begin
            pres_valid_o <= 1'b0;
            r_state      <= S_IDLE;
            busy_o       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_cnt_o = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_neureka_binconv_column_bitserial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_neureka_binconv_column_bitserial: scoreboard bench for the column.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_neureka_binconv_column_bitserial;

  localparam int CS    = 9;
  localparam int QA    = 8;
  localparam int QWM   = 8;
  localparam int SUM_W = QA + $clog2(CS) + 1;
  localparam int ACC_W = SUM_W + QWM + 1;
  localparam int QW_W  = $clog2(QWM + 1);
  localparam int BC_W  = $clog2(QWM);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 start = 1'b0;
  logic [QW_W-1:0]      qw = '0;
  logic                 signed_w = 1'b0;
  logic                 offset_mode = 1'b0;
  logic [3:0]           offset_shift = '0;
  logic [CS-1:0]        lane_en = '0;
  logic                 act_valid = 1'b0;
  logic [CS*QA-1:0]     act_data = '0;
  logic                 act_ready;
  logic                 wt_valid = 1'b0;
  logic [CS-1:0]        wt_data = '0;
  logic                 wt_ready;
  logic                 pres_valid;
  logic [ACC_W-1:0]     pres_data;
  logic                 pres_ready = 1'b0;
  logic                 busy;
  logic [BC_W-1:0]      bit_cnt;

  int errors = 0;
  int checks = 0;

  logic [QA-1:0]        act_lanes [CS];
  logic [CS-1:0]        wt_slices [16];
  logic [ACC_W-1:0]     sb [$];

  always #5 clk = ~clk;

  neureka_binconv_column_bitserial #(
    .COLUMN_SIZE(CS), .QA_IN(QA), .QW_MAX(QWM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .qw_i(qw), .signed_w_i(signed_w), .offset_mode_i(offset_mode),
    .offset_shift_i(offset_shift), .lane_en_i(lane_en),
    .act_valid_i(act_valid), .act_data_i(act_data), .act_ready_o(act_ready),
    .wt_valid_i(wt_valid), .wt_data_i(wt_data), .wt_ready_o(wt_ready),
    .pres_valid_o(pres_valid), .pres_data_o(pres_data), .pres_ready_i(pres_ready),
    .busy_o(busy), .bit_cnt_o(bit_cnt)
  );

  function automatic int eff_qw(input int q);
    return (q == 0) ? 1 : ((q > QWM) ? QWM : q);
  endfunction

  // Reference: integer weight per lane, dot product with activations
  function automatic logic [ACC_W-1:0] model(input int q_in, input bit sgn, input bit off,
                                             input int sh, input logic [CS-1:0] en);
    longint total = 0;
    int q = eff_qw(q_in);
    for (int l = 0; l < CS; l++) begin
      longint w = 0;
      if (en[l]) begin
        if (off) w = longint'(1) << sh;
        else
          for (int b = 0; b < q; b++)
            if (wt_slices[b][l]) w += (sgn && b == q - 1) ? -(longint'(1) << b) : (longint'(1) << b);
      end
      total += longint'(act_lanes[l]) * w;
    end
    return total[ACC_W-1:0];
  endfunction

  function automatic logic [CS*QA-1:0] pack_act();
    logic [CS*QA-1:0] p;
    for (int l = 0; l < CS; l++) p[l*QA +: QA] = act_lanes[l];
    return p;
  endfunction

  task automatic start_job(input int q, input bit sgn, input bit off, input int sh,
                           input logic [CS-1:0] en);
    qw = QW_W'(q); signed_w = sgn; offset_mode = off; offset_shift = 4'(sh); lane_en = en;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds all beats; returns ready-prediction errors (timeouts count heavily)
  task automatic drive_beats(input int q, input bit off, input bit stall, output int rdy_err);
    int nb = off ? 1 : eff_qw(q);
    int b = 0;
    int guard = 0;
    rdy_err = 0;
    while (b < nb && guard < 400) begin
      bit av = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bit wv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bit fire;
      act_valid = av; wt_valid = wv;
      act_data = pack_act(); wt_data = wt_slices[b];
      #1;
      if (act_ready !== (off | wv)) rdy_err++;
      if (wt_ready !== (!off & av)) rdy_err++;
      fire = av && (off || wv);
      @(posedge clk); #1;
      if (fire) b++;
      guard++;
    end
    if (b < nb) rdy_err += 1000;
    act_valid = 1'b0; wt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; act_valid = 1'b1; wt_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pres_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pres_valid); end
    checks++; if (pres_data !== '0) begin errors++; $display("FAIL reset_data got=%0d exp=0", pres_data); end
    checks++; if (busy !== 1'b0 || bit_cnt !== '0) begin errors++; $display("FAIL reset_busy_cnt got=%b/%0d exp=0/0", busy, bit_cnt); end
    checks++; if (act_ready !== 1'b0 || wt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", act_ready, wt_ready); end
    rst = 1'b0; act_valid = 1'b0; wt_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", act_ready); end
  endtask

  // Runs one job to its result, with the result handshake taken immediately
  task automatic run_and_check(input string name, input int q, input bit sgn, input bit off,
                               input int sh, input logic [CS-1:0] en, input bit stall,
                               output logic [ACC_W-1:0] got);
    int re;
    logic [ACC_W-1:0] exp;
    sb.push_back(model(q, sgn, off, sh, en));
    start_job(q, sgn, off, sh, en);
    drive_beats(q, off, stall, re);
    exp = sb.pop_front();
    got = pres_data;
    checks++; if (re !== 0) begin errors++; $display("FAIL %s_ready got_errs=%0d exp=0", name, re); end
    checks++; if (pres_valid !== 1'b1) begin errors++; $display("FAIL %s_latency valid=%b exp=1", name, pres_valid); end
    checks++; if (pres_data !== exp) begin errors++; $display("FAIL %s_data got=%0d exp=%0d", name, $signed(pres_data), $signed(exp)); end
    pres_ready = 1'b1;
    @(posedge clk); #1;
    pres_ready = 1'b0;
    checks++; if (pres_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_done valid=%b busy=%b exp=0/0", name, pres_valid, busy); end
  endtask

  task automatic test_unsigned();
    logic [ACC_W-1:0] g;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'd3;
    for (int b = 0; b < 16; b++) wt_slices[b] = (b < 4) ? '1 : '0;
    run_and_check("unsigned4", 4, 1'b0, 1'b0, 0, '1, 1'b0, g);
    checks++; if (g !== ACC_W'(405)) begin errors++; $display("FAIL unsigned_405 got=%0d exp=405", g); end
  endtask

  task automatic test_signed();
    logic [ACC_W-1:0] g;
    for (int l = 0; l < CS; l++) act_lanes[l] = (l == 0) ? 8'd10 : 8'd0;
    for (int b = 0; b < 16; b++) wt_slices[b] = (b < 4) ? CS'(1) : '0;
    run_and_check("signed4", 4, 1'b1, 1'b0, 0, '1, 1'b0, g);
    checks++; if (g !== ACC_W'(-10)) begin errors++; $display("FAIL signed_m10 got=%0d exp=-10", $signed(g)); end
    run_and_check("signed4_masked", 4, 1'b1, 1'b0, 0, {{(CS-1){1'b1}}, 1'b0}, 1'b0, g);
    checks++; if (g !== '0) begin errors++; $display("FAIL masked_zero got=%0d exp=0", g); end
  endtask

  task automatic test_offset();
    logic [ACC_W-1:0] g;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'd255;
    for (int b = 0; b < 16; b++) wt_slices[b] = '0;
    run_and_check("offset", 3, 1'b0, 1'b1, 2, '1, 1'b0, g);
    checks++; if (g !== ACC_W'(9180)) begin errors++; $display("FAIL offset_9180 got=%0d exp=9180", g); end
  endtask

  task automatic test_qw_bounds();
    logic [ACC_W-1:0] g;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'($urandom_range(0, 255));
    for (int b = 0; b < 16; b++) wt_slices[b] = CS'($urandom);
    run_and_check("qw0", 0, 1'b0, 1'b0, 0, '1, 1'b0, g);
    run_and_check("qw15_signed", 15, 1'b1, 1'b0, 0, '1, 1'b0, g);
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'd255;
    for (int b = 0; b < 16; b++) wt_slices[b] = (b == QWM - 1) ? '1 : '0;
    run_and_check("max_neg", QWM, 1'b1, 1'b0, 0, '1, 1'b0, g);
  endtask

  task automatic test_backpressure();
    int re;
    logic [ACC_W-1:0] exp;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'(l * 17 + 5);
    for (int b = 0; b < 16; b++) wt_slices[b] = CS'(9'h1A5 >> (b % 3));
    sb.push_back(model(5, 1'b1, 1'b0, 0, 9'h1F3));
    start_job(5, 1'b1, 1'b0, 0, 9'h1F3);
    drive_beats(5, 1'b0, 1'b0, re);
    exp = sb.pop_front();
    checks++; if (re !== 0) begin errors++; $display("FAIL bp_ready got_errs=%0d exp=0", re); end
    act_valid = 1'b1; wt_valid = 1'b1; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (pres_valid !== 1'b1 || pres_data !== exp || act_ready !== 1'b0 || wt_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d valid=%b data=%0d ardy=%b wrdy=%b exp=1/%0d/0/0",
                 c, pres_valid, $signed(pres_data), act_ready, wt_ready, $signed(exp));
      end
      @(posedge clk);
    end
    #1;
    pres_ready = 1'b1;
    @(posedge clk); #1;
    pres_ready = 1'b0; start = 1'b0; act_valid = 1'b0; wt_valid = 1'b0;
    checks++; if (pres_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid=%b busy=%b exp=0/0", pres_valid, busy); end
    checks++; if (pres_data !== exp) begin errors++; $display("FAIL bp_idle_hold got=%0d exp=%0d", pres_data, exp); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_stalls();
    logic [ACC_W-1:0] g0, g1;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'($urandom_range(0, 255));
    for (int b = 0; b < 16; b++) wt_slices[b] = CS'($urandom);
    run_and_check("nostall", 6, 1'b1, 1'b0, 0, 9'h1BF, 1'b0, g0);
    run_and_check("stall", 6, 1'b1, 1'b0, 0, 9'h1BF, 1'b1, g1);
    checks++; if (g1 !== g0) begin errors++; $display("FAIL stall_equal got=%0d exp=%0d", g1, g0); end
    run_and_check("stall_u8", 8, 1'b0, 1'b0, 0, '1, 1'b1, g1);
  endtask

  task automatic test_clear_rst();
    logic [ACC_W-1:0] g;
    int re;
    for (int l = 0; l < CS; l++) act_lanes[l] = 8'd3;
    for (int b = 0; b < 16; b++) wt_slices[b] = (b < 4) ? '1 : '0;
    start_job(4, 1'b0, 1'b0, 0, '1);
    act_valid = 1'b1; wt_valid = 1'b1; act_data = pack_act(); wt_data = wt_slices[0];
    @(posedge clk); #1;
    clear = 1'b1; wt_data = wt_slices[1];
    @(posedge clk); #1;
    clear = 1'b0; act_valid = 1'b0; wt_valid = 1'b0;
    checks++; if (busy !== 1'b0 || pres_valid !== 1'b0 || bit_cnt !== '0) begin errors++; $display("FAIL clear_abort busy=%b valid=%b cnt=%0d exp=0/0/0", busy, pres_valid, bit_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pres_valid !== 1'b0) begin errors++; $display("FAIL clear_no_result valid=%b exp=0", pres_valid); end
    run_and_check("after_clear", 4, 1'b0, 1'b0, 0, '1, 1'b0, g);
    sb.push_back(model(4, 1'b0, 1'b0, 0, '1));
    start_job(4, 1'b0, 1'b0, 0, '1);
    drive_beats(4, 1'b0, 1'b0, re);
    void'(sb.pop_front());
    checks++; if (pres_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_out valid=%b exp=1", pres_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (pres_valid !== 1'b0 || pres_data !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_out valid=%b data=%0d busy=%b exp=0/0/0", pres_valid, pres_data, busy); end
    run_and_check("after_rst", 4, 1'b0, 1'b0, 0, '1, 1'b0, g);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_offset();
    test_qw_bounds();
    test_backpressure();
    test_stalls();
    test_clear_rst();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
